// File: rtl/dl_pkg.sv
// Shared types and widths for the download router.
package dl_pkg;

  // Router sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    XFER   = 3'd1,
    DRAIN  = 3'd2,
    FIX_LO = 3'd3,
    FIX_HI = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Image type latched at the start of a download.
  typedef enum logic [1:0] {
    ROM  = 2'd0,
    PRG  = 2'd1,
    NONE = 2'd2
  } img_t;

  localparam int BYTE_W = 8;
  localparam int PTR_W  = 16;
  localparam int IDX_W  = 8;
  localparam int K_W    = 3;

endpackage

// File: rtl/dl_router_if.sv
// Memory write port of the download router.
//
// Handshake: the master raises wr with addr/data. All three stay stable
// until a cycle where wr && mem_ready, which is the single cycle on which
// the write is accepted. mem_ready may be high with wr low; that does
// nothing.
interface dl_router_if #(
  parameter int ADDR_W = 25
) ();
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;
  logic              mem_ready;

  modport master (output wr, output addr, output data, input mem_ready);
  modport slave  (input wr, input addr, input data, output mem_ready);
endinterface

// File: rtl/dl_fifo.sv
// Synchronous FIFO; push is ignored when full unless a pop happens in the
// same cycle, pop is ignored when empty.
module dl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rp];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) store[wp] <= din;
  end

  // Pointers and fill level.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dl_router.sv
// Routes data_io download bytes to memory, then patches end-of-program
// pointers after a program load.
module dl_router
  import dl_pkg::*;
#(
  parameter int                ADDR_W     = 25,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [7:0]        ROM_IDX    = 8'h00,
  parameter logic [7:0]        PRG_IDX_A  = 8'h01,
  parameter logic [7:0]        PRG_IDX_B  = 8'h41,
  parameter logic [ADDR_W-1:0] ROM_BASE   = 'h0,
  parameter logic [ADDR_W-1:0] PRG_BASE   = 'h8133,
  parameter int                NPTR       = 1,
  parameter logic [ADDR_W-1:0] PTR_ADDR_0 = 'h81BB,
  parameter logic [ADDR_W-1:0] PTR_ADDR_1 = 'h0,
  parameter logic [ADDR_W-1:0] PTR_ADDR_2 = 'h0,
  parameter logic [ADDR_W-1:0] PTR_ADDR_3 = 'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [IDX_W-1:0]  ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  dl_router_if.master       mem,
  output logic              downloading,
  output logic              rom_done,
  output logic              overflow,
  output state_t            dbg_state
);
  localparam int FW = ADDR_W + BYTE_W;
  localparam logic [ADDR_W-1:0] PTR_TAB [4] = '{PTR_ADDR_0, PTR_ADDR_1, PTR_ADDR_2, PTR_ADDR_3};

  state_t            state, state_n;
  img_t              img_q, img_dec;
  logic              dl_q, dl_rise, dl_fall;
  logic              seen, fixed;
  logic [ADDR_W-1:0] last_off;
  logic [K_W-1:0]    k;
  logic [PTR_W-1:0]  end_val;

  logic              push_req, pop;
  logic              fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_din, fifo_dout;
  logic [ADDR_W-1:0] base_addr;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              out_free;

  logic              start, finish, k_inc, fix_last, fix_load;
  logic [ADDR_W-1:0] fix_addr;
  logic [7:0]        fix_data;

  assign dl_rise   = ioctl_download && !dl_q;
  assign dl_fall   = !ioctl_download && dl_q;
  assign base_addr = (img_q == ROM) ? ROM_BASE : PRG_BASE;
  assign push_req  = (state == XFER) && ioctl_wr && (img_q != NONE);
  assign fifo_din  = {ioctl_addr + base_addr, ioctl_dout};
  // The output register only reloads on a cycle where memory is ready, so
  // a stalled request never hides an extra byte outside the FIFO.
  assign pop       = !fifo_empty && mem.mem_ready;
  assign out_free  = !wr_q || mem.mem_ready;
  assign end_val   = 16'(PRG_BASE + last_off + ADDR_W'(1));
  assign dbg_state = state;

  assign mem.wr   = wr_q;
  assign mem.addr = addr_q;
  assign mem.data = data_q;

  dl_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Index decode, sampled when a download starts.
  always_comb begin
    img_dec = NONE;
    if (ioctl_index == ROM_IDX) img_dec = ROM;
    else if (ioctl_index == PRG_IDX_A || ioctl_index == PRG_IDX_B) img_dec = PRG;
  end

  // Next-state logic and fixup request generation.
  always_comb begin
    state_n  = state;
    start    = 1'b0;
    finish   = 1'b0;
    k_inc    = 1'b0;
    fix_last = 1'b0;
    fix_load = 1'b0;
    fix_addr = '0;
    fix_data = '0;
    case (state)
      IDLE: if (dl_rise) begin
        start   = 1'b1;
        state_n = XFER;
      end
      XFER: if (dl_fall) state_n = DRAIN;
      DRAIN: if (fifo_empty && out_free) begin
        if (img_q == PRG && seen && NPTR > 0 && !fixed) state_n = FIX_LO;
        else state_n = DONE;
      end
      FIX_LO: if (mem.mem_ready) begin
        fix_load = 1'b1;
        fix_addr = PTR_TAB[k[1:0]];
        fix_data = end_val[7:0];
        state_n  = FIX_HI;
      end
      FIX_HI: if (mem.mem_ready) begin
        fix_load = 1'b1;
        fix_addr = PTR_TAB[k[1:0]] + ADDR_W'(1);
        fix_data = end_val[15:8];
        if (int'(k) == NPTR - 1) begin
          // Back through DRAIN so the last pointer write is accepted first.
          fix_last = 1'b1;
          state_n  = DRAIN;
        end else begin
          k_inc   = 1'b1;
          state_n = FIX_LO;
        end
      end
      DONE: begin
        finish  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and download bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      img_q       <= NONE;
      dl_q        <= 1'b0;
      seen        <= 1'b0;
      fixed       <= 1'b0;
      last_off    <= '0;
      k           <= '0;
      downloading <= 1'b0;
      rom_done    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= state_n;
      dl_q  <= ioctl_download;
      if (start) begin
        img_q       <= img_dec;
        downloading <= 1'b1;
        seen        <= 1'b0;
        fixed       <= 1'b0;
        last_off    <= '0;
        k           <= '0;
      end
      if (push_req) begin
        seen     <= 1'b1;
        last_off <= ioctl_addr;
        if (fifo_full && !pop) overflow <= 1'b1;
      end
      if (k_inc)    k     <= k + K_W'(1);
      if (fix_last) fixed <= 1'b1;
      if (finish) begin
        downloading <= 1'b0;
        if (img_q == ROM) rom_done <= 1'b1;
      end
    end
  end

  // Registered memory request: reload from FIFO head or fixup, else retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (pop) begin
      wr_q   <= 1'b1;
      addr_q <= fifo_dout[FW-1:BYTE_W];
      data_q <= fifo_dout[BYTE_W-1:0];
    end else if (fix_load) begin
      wr_q   <= 1'b1;
      addr_q <= fix_addr;
      data_q <= fix_data;
    end else if (mem.mem_ready) begin
      wr_q <= 1'b0;
    end
  end
endmodule
